// File: rtl/uart_tx_emitter.sv
// uart_tx_emitter: 8N1 transmit-only UART with valid/ready byte intake and a busy status word.
// The line and ready are registered, so o_uart_tx is glitch-free.
module uart_tx_emitter #(
  parameter int clk_freq_hz = 12000000,
  parameter int baud_rate   = 9600
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_uart_tx,
  output logic [31:0] o_status
);
  localparam int DIV = clk_freq_hz / baud_rate;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_emitter: clk_freq_hz / baud_rate must be at least 2");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [3:0]      r_idx;
  logic [8:0]      r_shift;
  logic            r_tx;
  logic            r_ready;
  logic            w_wrap;
  assign w_wrap    = r_cnt == CW'(DIV - 1);
  assign o_ready   = r_ready;
  assign o_uart_tx = r_tx;
  assign o_status  = {22'b0, ~r_ready, 9'b0};
  // The start bit goes straight onto the line at accept; r_shift holds data plus stop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '1;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
    end else if (r_state == IDLE) begin
      if (i_valid) begin
        r_shift <= {1'b1, i_data};
        r_tx    <= 1'b0;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_ready <= 1'b0;
        r_state <= SEND;
      end
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 4'd1;
      if (r_idx == 4'd9) begin
        r_state <= IDLE;
        r_ready <= 1'b1;
        r_tx    <= 1'b1;
      end else begin
        r_tx    <= r_shift[0];
        r_shift <= {1'b1, r_shift[8:1]};
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_emitter.sv
// tb_uart_tx_emitter: directed checks of framing, timing, busy drop, back-to-back and reset abort.
module tb_uart_tx_emitter;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  d0 = '0, d1 = '0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        r0, r1, t0, t1;
  logic [31:0] s0, s1;
  int          nchk = 0;
  int          nbad = 0;
  always #5 clk = ~clk;
  uart_tx_emitter #(.clk_freq_hz(16), .baud_rate(4)) u_small (
    .clk(clk), .resetn(resetn), .i_data(d0), .i_valid(v0),
    .o_ready(r0), .o_uart_tx(t0), .o_status(s0)
  );
  uart_tx_emitter u_dflt (
    .clk(clk), .resetn(resetn), .i_data(d1), .i_valid(v1),
    .o_ready(r1), .o_uart_tx(t1), .o_status(s1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  // Entered at the negedge right after the accept edge; leaves one edge after the frame ends.
  task automatic frame(input int sel, input logic [7:0] b, input int div, input bit hold,
                       input int drop_at, input int rst_at, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int e = 0; e < 10 * div; e++) begin
      chk({tag, "_tx"}, 32'(sel ? t1 : t0), 32'(f[e / div]));
      chk({tag, "_rdy"}, 32'(sel ? r1 : r0), 32'd0);
      chk({tag, "_st"}, sel ? s1 : s0, 32'h200);
      if (e == rst_at) begin
        resetn = 1'b0;
        tick();
        chk({tag, "_rst_tx"}, 32'(sel ? t1 : t0), 32'd1);
        chk({tag, "_rst_rdy"}, 32'(sel ? r1 : r0), 32'd1);
        chk({tag, "_rst_st"}, sel ? s1 : s0, 32'h0);
        resetn = 1'b1;
        return;
      end
      if (e == 0) begin
        if (sel != 0) begin
          v1 = 1'b0;
          d1 = ~b;
        end else begin
          v0 = hold;
          d0 = ~b;
        end
      end
      if (drop_at >= 0 && e == drop_at) begin
        v0 = 1'b1;
        d0 = 8'hFF;
      end
      if (drop_at >= 0 && e == drop_at + 1) v0 = 1'b0;
      tick();
    end
    chk({tag, "_end_tx"}, 32'(sel ? t1 : t0), 32'd1);
    chk({tag, "_end_rdy"}, 32'(sel ? r1 : r0), 32'd1);
    chk({tag, "_end_st"}, sel ? s1 : s0, 32'h0);
  endtask
  initial begin
    @(negedge clk);
    repeat (3) tick();
    chk("rst_tx", 32'(t0), 32'd1);
    chk("rst_rdy", 32'(r0), 32'd1);
    chk("rst_st", s0, 32'h0);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_tx", 32'(t0), 32'd1);
      chk("idle_rdy", 32'(r0), 32'd1);
      chk("idle_st", s0, 32'h0);
      chk("idle_dflt_st", s1, 32'h0);
    end
    v0 = 1'b1; d0 = 8'h55;
    tick();
    frame(0, 8'h55, 4, 1'b0, -1, -1, "b55");
    tick();
    v0 = 1'b1; d0 = 8'hA3;
    tick();
    frame(0, 8'hA3, 4, 1'b0, 10, -1, "drop");
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drop_after_tx", 32'(t0), 32'd1);
      chk("drop_after_rdy", 32'(r0), 32'd1);
    end
    v0 = 1'b1; d0 = 8'h00;
    tick();
    frame(0, 8'h00, 4, 1'b1, -1, -1, "b2b0");
    tick();
    frame(0, 8'hFF, 4, 1'b0, -1, -1, "b2b1");
    tick();
    v0 = 1'b1; d0 = 8'h0F;
    tick();
    frame(0, 8'h0F, 4, 1'b0, -1, 12, "rstmid");
    v0 = 1'b0;
    tick();
    chk("post_rst_tx", 32'(t0), 32'd1);
    v0 = 1'b1; d0 = 8'h81;
    tick();
    frame(0, 8'h81, 4, 1'b0, -1, -1, "b81");
    v1 = 1'b1; d1 = 8'h41;
    tick();
    frame(1, 8'h41, 1250, 1'b0, -1, -1, "dflt");
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end
endmodule
